muldiv_unit: RTL and testbench

Iterative multiply/divide unit that owns the HI/LO register pair for the execute stage. It sits beside the combinational ALU in the execute stage and feeds its hi/lo values to the ALU, which reads them for MFHI/MFLO. MULT/MULTU/DIV/DIVU run over multiple cycles and raise busy so that decode can stall. MTHI/MTLO write in a single cycle.

---
 rtl/muldiv_unit_pkg.sv | 10 +
 rtl/muldiv_unit_iterative_divider.sv | 48 ++++
 rtl/muldiv_unit.sv | 102 ++++++++++
 tb/tb_muldiv_unit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: op codes shared by the multiply/divide unit and decode
package muldiv_unit_pkg;
  localparam int MDU_OP_WIDTH = 3;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MULT  = 3'd0;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MULTU = 3'd1;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_DIV   = 3'd2;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_DIVU  = 3'd3;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MTHI  = 3'd4;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MTLO  = 3'd5;
endpackage

// File: rtl/muldiv_unit_iterative_divider.sv
// muldiv_unit_iterative_divider: restoring unsigned divider, one quotient bit per cycle
module muldiv_unit_iterative_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quot,
  output logic [DATA_WIDTH-1:0] rem
);
  localparam int CW = $clog2(DATA_WIDTH);
  logic                  running;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] dvs;
  logic [DATA_WIDTH:0]   trial;
  logic                  fits;
  always_comb begin
    trial = {rem, quot[DATA_WIDTH-1]};
    fits = trial >= {1'b0, dvs};
    done = running && cnt == CW'(DATA_WIDTH - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt <= '0;
      dvs <= '0;
      quot <= '0;
      rem <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt <= '0;
      dvs <= divisor;
      quot <= dividend;
      rem <= '0;
    end else if (abort) begin
      running <= 1'b0;
    end else if (running) begin
      running <= !done;
      cnt <= cnt + 1'b1;
      quot <= {quot[DATA_WIDTH-2:0], fits};
      rem <= fits ? DATA_WIDTH'(trial - {1'b0, dvs}) : trial[DATA_WIDTH-1:0];
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit owning the HI/LO register pair
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int MDU_OP_WIDTH = muldiv_unit_pkg::MDU_OP_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MDU_OP_WIDTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]   rs,
  input  logic [DATA_WIDTH-1:0]   rt,
  input  logic                    flush,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   hi,
  output logic [DATA_WIDTH-1:0]   lo
);
  import muldiv_unit_pkg::*;
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [DATA_WIDTH-1:0]   mcand, acc, mplr;
  logic                    is_div, neg_res, neg_rem, div0;
  logic                    op_mul, op_div, sa, sb, div_start, div_done, last;
  logic [DATA_WIDTH-1:0]   mag_a, mag_b, quot, rem, q_fix, r_fix;
  logic [DATA_WIDTH:0]     sum;
  logic [2*DATA_WIDTH-1:0] p_fix;
  always_comb begin
    op_mul = op == MDU_OP_MULT || op == MDU_OP_MULTU;
    op_div = op == MDU_OP_DIV || op == MDU_OP_DIVU;
    sa = (op == MDU_OP_MULT || op == MDU_OP_DIV) && rs[DATA_WIDTH-1];
    sb = (op == MDU_OP_MULT || op == MDU_OP_DIV) && rt[DATA_WIDTH-1];
    mag_a = sa ? -rs : rs;
    mag_b = sb ? -rt : rt;
    div_start = state == IDLE && start && !flush && op_div;
    sum = {1'b0, acc} + {1'b0, (mplr[0] ? mcand : {DATA_WIDTH{1'b0}})};
    last = is_div ? div_done : cnt == CW'(DATA_WIDTH - 1);
    p_fix = neg_res ? -{acc, mplr} : {acc, mplr};
    q_fix = div0 ? '1 : neg_res ? -quot : quot;
    r_fix = neg_rem ? -rem : rem;
  end
  muldiv_unit_iterative_divider #(.DATA_WIDTH(DATA_WIDTH)) u_div (
    .clk(clk),
    .rst(rst),
    .start(div_start),
    .abort(flush),
    .dividend(mag_a),
    .divisor(mag_b),
    .done(div_done),
    .quot(quot),
    .rem(rem)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      mcand <= '0;
      acc <= '0;
      mplr <= '0;
      is_div <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0 <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy <= 1'b0;
      end else if (state == IDLE) begin
        if (start && op == MDU_OP_MTHI) hi <= rs;
        if (start && op == MDU_OP_MTLO) lo <= rs;
        if (start && (op_mul || op_div)) begin
          state <= CALC;
          busy <= 1'b1;
          cnt <= '0;
          mcand <= mag_a;
          acc <= '0;
          mplr <= mag_b;
          is_div <= op_div;
          neg_res <= sa ^ sb;
          neg_rem <= sa;
          div0 <= rt == '0;
        end
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        acc <= sum[DATA_WIDTH:1];
        mplr <= {sum[0], mplr[DATA_WIDTH-1:1]};
        if (last) state <= FIX;
      end else begin
        state <= IDLE;
        busy <= 1'b0;
        done <= 1'b1;
        {hi, lo} <= is_div ? {r_fix, q_fix} : p_fix;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector self-checking bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          vectors = 0;
  int          miscompares = 0;
  always #5 clk = ~clk;
  muldiv_unit dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(op),
    .rs(rs),
    .rt(rt),
    .flush(flush),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op = o;
    rs = a;
    rt = b;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_hi,
                     input logic [31:0] exp_lo, input bit inject);
    int busy_cycles = 0;
    int dones = 0;
    int n = 0;
    issue(o, a, b);
    while (busy && n < 100) begin
      busy_cycles++;
      dones += int'(done);
      if (inject && n == 5) begin
        start = 1'b1;
        op = MDU_OP_DIVU;
        rs = 32'd9;
        rt = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, " done_at_end"}, done, 1);
    chk({tag, " hi"}, hi, exp_hi);
    chk({tag, " lo"}, lo, exp_lo);
    chk({tag, " busy_cycles"}, busy_cycles, 33);
    @(negedge clk);
    dones += int'(done);
    chk({tag, " extra_done"}, dones, 0);
  endtask
  initial begin
    int dones;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    run("mult -3*7", MDU_OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    run("multu max", MDU_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    run("mult -1*-1", MDU_OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 0);
    run("div -7/2", MDU_OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run("divu 7/0", MDU_OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 0);
    run("div -7/0", MDU_OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 0);
    run("div min/-1", MDU_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0);
    run("div 100/-7", MDU_OP_DIV, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 0);
    @(negedge clk);
    start = 1'b1;
    op = MDU_OP_MTHI;
    rs = 32'h12345678;
    @(negedge clk);
    chk("mthi hi", hi, 32'h12345678);
    chk("mthi busy", busy, 0);
    op = MDU_OP_MTLO;
    rs = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo lo", lo, 32'h9ABCDEF0);
    chk("mtlo hi kept", hi, 32'h12345678);
    chk("mtlo busy", busy, 0);
    chk("mtlo done", done, 0);
    start = 1'b1;
    op = 3'd7;
    rs = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    chk("unknown op busy", busy, 0);
    chk("unknown op hi", hi, 32'h12345678);
    start = 1'b1;
    flush = 1'b1;
    op = MDU_OP_MTHI;
    rs = 32'hCAFEF00D;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("flush+start hi", hi, 32'h12345678);
    chk("flush+start busy", busy, 0);
    issue(MDU_OP_MULT, 32'd5, 32'd5);
    repeat (9) @(negedge clk);
    chk("flush pre busy", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", busy, 0);
    dones = 0;
    repeat (40) begin
      dones += int'(done);
      @(negedge clk);
    end
    chk("flush no done", dones, 0);
    chk("flush hi kept", hi, 32'h12345678);
    chk("flush lo kept", lo, 32'h9ABCDEF0);
    run("mult 2*3", MDU_OP_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 0);
    run("divu 100/7 ignore start", MDU_OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1);
    issue(MDU_OP_DIVU, 32'd1000, 32'd3);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst mid hi", hi, 0);
    chk("rst mid lo", lo, 0);
    chk("rst mid busy", busy, 0);
    dones = 0;
    repeat (40) begin
      dones += int'(done);
      @(negedge clk);
    end
    chk("rst mid no done", dones, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
